// File: rtl/qpsk_pkg.sv
// Shared types and defaults for the differential QPSK phase path.
package qpsk_pkg;

   localparam int DEFAULT_SPS           = 8;
   localparam int DEFAULT_SAMPLE_OFFSET = 4;
   localparam int IQ_W                  = 32;

   typedef struct packed {
      logic signed [15:0] i;
      logic signed [15:0] q;
   } iq_t;

   typedef struct packed {
      iq_t prev;
      iq_t curr;
   } iq_pair_t;

   // One output-buffer entry: the pair plus its frame-end flag.
   typedef struct packed {
      logic     last;
      iq_pair_t pair;
   } pair_beat_t;

   function automatic logic iq_is_zero(input iq_t s);
      return (s.i == 16'sd0) && (s.q == 16'sd0);
   endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI-Stream buffer. The input ready is registered from the next occupancy,
// so it has no combinational path from the output ready.
module axis_fifo2 #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [1:0]       count_r;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] tail_r;
   logic             ready_r;
   logic             valid_r;
   logic             push_s;
   logic             pop_s;
   logic [1:0]       count_nxt_s;
   logic [WIDTH-1:0] head_nxt_s;
   logic [WIDTH-1:0] tail_nxt_s;

   assign push_s = in_valid && (count_r != 2'd2);
   assign pop_s  = valid_r && out_ready;

   // Next occupancy and entry contents for each push/pop combination.
   always_comb begin
      count_nxt_s = count_r;
      head_nxt_s  = head_r;
      tail_nxt_s  = tail_r;
      case ({push_s, pop_s})
         2'b10: begin
            count_nxt_s = count_r + 2'd1;
            if (count_r == 2'd0) begin
               head_nxt_s = in_data;
            end else begin
               tail_nxt_s = in_data;
            end
         end
         2'b01: begin
            count_nxt_s = count_r - 2'd1;
            head_nxt_s  = tail_r;
         end
         2'b11: begin
            // Occupancy is unchanged; the new entry goes behind whatever remains.
            if (count_r == 2'd1) begin
               head_nxt_s = in_data;
            end else begin
               head_nxt_s = tail_r;
               tail_nxt_s = in_data;
            end
         end
         default: begin
            count_nxt_s = count_r;
         end
      endcase
   end

   // Buffer state and registered handshake flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= 2'd0;
         head_r  <= {WIDTH{1'b0}};
         tail_r  <= {WIDTH{1'b0}};
         ready_r <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         head_r  <= head_nxt_s;
         tail_r  <= tail_nxt_s;
         ready_r <= (count_nxt_s < 2'd2);
         valid_r <= (count_nxt_s != 2'd0);
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = valid_r;
   assign out_data  = head_r;

endmodule

// File: rtl/iq_pair_former_chk.sv
// Elaboration-time parameter checks for iq_pair_former.
module iq_pair_former_chk #(
   parameter int SPS           = 8,
   parameter int SAMPLE_OFFSET = 4
) ();

   if ((SPS < 1) || (SAMPLE_OFFSET < 0) || (SAMPLE_OFFSET >= SPS)) begin : g_bad_params
      $error("iq_pair_former: need SPS >= 1 and 0 <= SAMPLE_OFFSET < SPS (SPS=%0d, SAMPLE_OFFSET=%0d)",
             SPS, SAMPLE_OFFSET);
   end

endmodule

// File: rtl/iq_pair_former.sv
// Decimates an IQ stream to one sample per symbol and emits {previous, current} pairs.
// Define IQ_PAIR_ZERO_SKIP_EN to drop decimated samples with I==0 and Q==0.
module iq_pair_former
   import qpsk_pkg::*;
#(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,
   parameter int SPS                    = DEFAULT_SPS,
   parameter int SAMPLE_OFFSET          = DEFAULT_SAMPLE_OFFSET
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_areset,
   input  logic                                s00_axis_tvalid,
   output logic                                s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                                s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   output logic                                m00_axis_tvalid,
   input  logic                                m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic [15:0]                         pair_count
);

   localparam int               CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] OFFSET_C = CNT_W'(SAMPLE_OFFSET);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(SPS - 1);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

   iq_pair_former_chk #(
      .SPS           (SPS),
      .SAMPLE_OFFSET (SAMPLE_OFFSET)
   ) u_chk ();

   logic [CNT_W-1:0] cnt_r;
   logic             have_prev_r;
   iq_t              prev_r;
   logic [15:0]      pair_count_r;
   iq_t              sample_s;
   logic             tready_s;
   logic             accept_s;
   logic             is_sym_s;
   logic             keep_s;
   logic             push_s;
   logic             pop_s;
   logic             head_valid_s;
   pair_beat_t       push_beat_s;
   pair_beat_t       head_beat_s;
   logic             unused_s;

   assign unused_s = ^s00_axis_tstrb;
   assign sample_s = s00_axis_tdata[IQ_W-1:0];
   assign accept_s = s00_axis_tvalid && tready_s;
   assign is_sym_s = accept_s && (cnt_r == OFFSET_C);

`ifdef IQ_PAIR_ZERO_SKIP_EN
   // A zero symbol would become a zero divisor in the phase stage.
   assign keep_s = is_sym_s && !iq_is_zero(sample_s);
`else
   assign keep_s = is_sym_s;
`endif

   assign push_s = keep_s && have_prev_r;

   // Pair written into the buffer; tlast rides along from the pushing beat.
   always_comb begin
      push_beat_s.last      = s00_axis_tlast;
      push_beat_s.pair.prev = prev_r;
      push_beat_s.pair.curr = sample_s;
   end

   // Symbol phase counter and previous-symbol history; a frame end clears both.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         cnt_r       <= ZERO_C;
         have_prev_r <= 1'b0;
         prev_r      <= iq_t'(32'h0000_0000);
      end else if (accept_s) begin
         if (s00_axis_tlast) begin
            cnt_r       <= ZERO_C;
            have_prev_r <= 1'b0;
         end else begin
            cnt_r <= (cnt_r == LAST_C) ? ZERO_C : (cnt_r + ONE_C);
            if (keep_s) begin
               have_prev_r <= 1'b1;
            end
         end
         if (keep_s) begin
            prev_r <= sample_s;
         end
      end
   end

   axis_fifo2 #(
      .WIDTH ($bits(pair_beat_t))
   ) u_fifo (
      .clk       (s00_axis_aclk),
      .rst       (s00_axis_areset),
      .in_valid  (push_s),
      .in_ready  (tready_s),
      .in_data   (push_beat_s),
      .out_valid (head_valid_s),
      .out_ready (m00_axis_tready),
      .out_data  (head_beat_s)
   );

   assign pop_s = head_valid_s && m00_axis_tready;

   // Count of completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         pair_count_r <= 16'd0;
      end else if (pop_s) begin
         pair_count_r <= pair_count_r + 16'd1;
      end
   end

   assign s00_axis_tready = tready_s;
   assign m00_axis_tvalid = head_valid_s;
   assign m00_axis_tdata  = head_beat_s.pair;
   assign m00_axis_tlast  = head_beat_s.last;
   assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};
   assign pair_count      = pair_count_r;

endmodule

// File: doc/iq_pair_former.md
# iq_pair_former

Front-end stage of the differential QPSK phase path. It accepts a stream of 32-bit IQ samples and decimates it to one sample per symbol at a fixed offset. Each decimated symbol is paired with the previous one, and the block emits a 64-bit {previous, current} word, which is the exact input format of the phase-extraction stage that consumes it. A 2-entry output buffer absorbs backpressure without dropping symbols.

## Interface
Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width: I in [31:16], Q in [15:0], both signed.
- C_M00_AXIS_TDATA_WIDTH, 64, output pair width: previous symbol in [63:32], current symbol in [31:0].
- SPS, 8, samples per symbol; must be ≥1.
- SAMPLE_OFFSET, 4, index of the sample taken within each symbol period; must be < SPS.

Ports:
- s00_axis_aclk  in  1  single clock for the whole block.
- s00_axis_areset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tready  out  1  input ready; registered.
- s00_axis_tdata  in  32  IQ sample.
- s00_axis_tlast  in  1  frame end.
- s00_axis_tstrb  in  4  ignored.
- m00_axis_tvalid  out  1  pair valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  64  {prev, curr}.
- m00_axis_tlast  out  1  pair closes a frame.
- m00_axis_tstrb  out  8  constant all-ones.
- pair_count  out  16  count of emitted pairs; wraps.

## Operation
- Accept: an input beat is accepted when s00_axis_tvalid && s00_axis_tready.
- Phase counter `cnt`, range 0..SPS-1:
  - Increments on every accepted beat and wraps to 0.
  - The beat accepted while cnt==SAMPLE_OFFSET is the decimated symbol.
- History: register `prev` plus flag `have_prev`.
  - On a decimated symbol with have_prev=1: push {prev, curr} into the buffer.
  - On every decimated symbol: prev←curr and have_prev←1.
- Frame end (accepted beat with s00_axis_tlast=1):
  - The beat itself is processed first.
  - Then cnt←0 and have_prev←0.
  - If that beat pushed a pair, the pair carries tlast=1. Otherwise no pair in the frame carries tlast.
- Output buffer: 2-entry FIFO.
  - m00_axis_tvalid = occupancy≠0.
  - tdata and tlast come from the head entry and stay stable while tvalid && !tready.
- Push and pop in the same cycle leave occupancy unchanged.
- A push into a full buffer cannot occur, because tready is low when full.
- pair_count increments on each m00 handshake; 0xFFFF wraps to 0.
- Arithmetic: none on data; samples pass bit-exact.

## Timing
- Reset values:
  - s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, pair_count=0.
  - Internal state: cnt=0, have_prev=0, occupancy=0.
- First cycle after reset deasserts: s00_axis_tready=1.
- s00_axis_tready is registered as (next occupancy < 2). It has no combinational path from m00_axis_tready.
- Latency: a pushing beat accepted in cycle N into an empty buffer gives m00_axis_tvalid=1 in cycle N+1.
- Throughput: with m00_axis_tready held high, the block sustains one pair per cycle at SPS=1.
- Reset asserted mid-operation: buffered pairs are discarded and all registers return to reset values on the next edge.
- SPS=1: every accepted sample is a decimated symbol.

## Configuration
- IQ_PAIR_ZERO_SKIP_EN:
  - Defined: a decimated sample with I==0 and Q==0 is dropped. No push occurs, and prev and have_prev are unchanged. cnt still advances. tlast on that beat still clears history. This prevents a zero divisor downstream.
  - Undefined: zero samples are treated like any other sample.

## Structure
- Shared package qpsk_pkg contains:
  - iq_t: packed struct of signed 16-bit I and Q.
  - iq_pair_t: packed {iq_t prev, iq_t curr}.
  - Default SPS constant.
- Sub-module axis_fifo2 (2-entry, registered ready) implements the output buffer.
- Elaboration-time assertion: SAMPLE_OFFSET < SPS and SPS ≥ 1.

## Test plan
- Decimation: SPS=4, OFFSET=1, samples tdata=k for k=0..11, tready=1 → exactly two pairs, {1,5} then {5,9}. pair_count=2.
- Backpressure: SPS=1, m00_axis_tready=0 for 10 cycles while streaming 1,2,3,4 → two pairs buffered and s00_axis_tready=0. On release, pairs {1,2},{2,3},{3,4} come out in order with no loss or duplication.
- Frame: SPS=4, OFFSET=1, tlast on k=5 → pair {1,5} with tlast=1. The next frame's first decimated sample (k=7) emits nothing, and k=11 emits {7,11}.
- Mid-stream reset: buffer full, pulse s00_axis_areset for 1 cycle → next cycle m00_axis_tvalid=0 and pair_count=0. The first decimated sample after reset emits nothing.
- Zero skip: SPS=1, samples 3, 0, 7.
  - Macro defined: {3,7} only.
  - Macro undefined: {3,0} and {0,7}.
- Counter wrap: preload 65535 handshakes, then 1 more → pair_count=0.
